// File: rtl/ofifo_drain_ctrl.sv
// ofifo_drain_ctrl: pops psum vectors from the ofifo and writes them to consecutive psum SRAM addresses.
// Define OFIFO_DRAIN_RELU_EN to clamp negative lanes to zero on the way to SRAM.
module ofifo_drain_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [addr_w-1:0]        i_base_addr,
    input  logic [addr_w-1:0]        i_len,
    input  logic                     i_ofifo_valid,
    output logic                     o_ofifo_rd,
    input  logic [col*psum_bw-1:0]   i_ofifo_out,
    output logic                     o_pmem_cen,
    output logic                     o_pmem_wen,
    output logic [addr_w-1:0]        o_pmem_addr,
    output logic [col*psum_bw-1:0]   o_pmem_din,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int W = col * psum_bw;
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;
    state_t            r_state;
    logic [addr_w-1:0] r_wr_ptr, r_len, r_issued, r_addr_hold;
    logic [W-1:0]      r_din_hold, w_din;
    logic              r_rd_d, w_rd;
    assign w_rd = (r_state == S_DRAIN) && i_ofifo_valid && (r_issued != r_len);
    for (genvar k = 0; k < col; k++) begin : g_lane
`ifdef OFIFO_DRAIN_RELU_EN
        assign w_din[k*psum_bw +: psum_bw] = i_ofifo_out[(k+1)*psum_bw-1] ? '0 : i_ofifo_out[k*psum_bw +: psum_bw];
`else
        assign w_din[k*psum_bw +: psum_bw] = i_ofifo_out[k*psum_bw +: psum_bw];
`endif
    end
    // address and data hold their last written value between writes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_addr_hold <= '0;
            r_din_hold  <= '0;
            r_rd_d      <= 1'b0;
        end else begin
            r_rd_d <= w_rd;
            if (r_rd_d) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_addr_hold <= r_wr_ptr;
                r_din_hold  <= w_din;
            end
            if (w_rd) r_issued <= r_issued + 1'b1;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_wr_ptr <= i_base_addr;
                    r_len    <= i_len;
                    r_issued <= '0;
                    r_state  <= (i_len != '0) ? S_DRAIN : S_DONE;
                end
                S_DRAIN: if (w_rd && addr_w'(r_issued + 1'b1) == r_len) r_state <= S_FLUSH;
                S_FLUSH: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign o_ofifo_rd  = w_rd;
    assign o_pmem_cen  = ~r_rd_d;
    assign o_pmem_wen  = ~r_rd_d;
    assign o_pmem_addr = r_rd_d ? r_wr_ptr : r_addr_hold;
    assign o_pmem_din  = r_rd_d ? w_din : r_din_hold;
    assign o_busy      = (r_state == S_DRAIN) || (r_state == S_FLUSH);
    assign o_done      = (r_state == S_DONE);
endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// tb_ofifo_drain_ctrl: randomized drain jobs checked against a queue-based transaction model.
module tb_ofifo_drain_ctrl;
    localparam int COL = 8, BW = 16, AW = 11, W = COL * BW;
    logic clk = 0, rst = 1, start = 0, valid = 0;
    logic [AW-1:0] base = '0, len = '0;
    logic [W-1:0]  fdata = '0;
    logic          o_rd, o_cen, o_wen, o_busy, o_done;
    logic [AW-1:0] o_addr;
    logic [W-1:0]  o_din;
    logic [AW-1:0] last_addr = '0;
    logic [W-1:0]  last_din = '0;
    int n_cmp = 0, n_err = 0;

    ofifo_drain_ctrl #(.col(COL), .psum_bw(BW), .addr_w(AW)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_base_addr(base), .i_len(len),
        .i_ofifo_valid(valid), .o_ofifo_rd(o_rd), .i_ofifo_out(fdata),
        .o_pmem_cen(o_cen), .o_pmem_wen(o_wen), .o_pmem_addr(o_addr), .o_pmem_din(o_din),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] relu(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
`ifdef OFIFO_DRAIN_RELU_EN
        for (int k = 0; k < COL; k++) if (v[k*BW+BW-1]) r[k*BW +: BW] = '0;
`endif
        return r;
    endfunction

    function automatic logic pick(input int mode, input int c);
        logic [6:0] pat;
        pat = 7'b1011001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[c % 7];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic idle_checks(input string tag);
        chk({tag, "_rd"}, o_rd, 0);
        chk({tag, "_cen"}, o_cen, 1);
        chk({tag, "_wen"}, o_wen, 1);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_addr"}, o_addr, last_addr);
        chk({tag, "_din"}, o_din, last_din);
    endtask

    task automatic run_job(input logic [AW-1:0] b, input logic [AW-1:0] n, input int mode,
                           input int vkind, input bit rst2);
        logic [W-1:0]  vec[$];
        logic [W-1:0]  v;
        logic [AW-1:0] ea;
        int  popped = 0, wr_cnt = 0, c = 0;
        bit  wr_pend = 0, fin = 0, exp_rd, exp_done, do_rst;
        for (int i = 0; i < int'(n) + 2; i++) begin
            for (int k = 0; k < COL; k++)
                v[k*BW +: BW] = (vkind == 0) ? BW'(i + 1) :
                                (vkind == 2) ? ((k % 2 == 0) ? 16'hFFF6 : 16'h0005) : BW'($urandom);
            vec.push_back(v);
        end
        base = b; len = n; start = 1; valid = 0;
        @(negedge clk);
        idle_checks("start");
        @(posedge clk); #1;
        start = 0;
        valid = pick(mode, 0);
        while (!fin && c < 300) begin
            @(negedge clk);
            exp_rd   = (popped < int'(n)) && valid;
            exp_done = (wr_cnt == int'(n)) && !wr_pend;
            chk("rd", o_rd, exp_rd);
            chk("cen", o_cen, !wr_pend);
            chk("wen", o_wen, !wr_pend);
            chk("busy", o_busy, (popped < int'(n)) || wr_pend);
            chk("done", o_done, exp_done);
            if (wr_pend) begin
                ea = b + AW'(wr_cnt);
                last_addr = ea;
                last_din  = relu(vec[wr_cnt]);
                wr_cnt++;
            end
            chk("addr", o_addr, last_addr);
            chk("din", o_din, last_din);
            wr_pend = exp_rd;
            if (exp_rd) popped++;
            if (exp_done) fin = 1;
            do_rst = rst2 && exp_rd && popped == 2;
            @(posedge clk); #1;
            c++;
            if (wr_pend) fdata = vec[popped-1];
            if (do_rst) begin
                rst = 1; valid = 0;
                @(negedge clk);
                chk("prerst_cen", o_cen, 0);
                chk("prerst_addr", o_addr, b + AW'(1));
                @(posedge clk); #1;
                rst = 0; valid = 1;
                last_addr = '0; last_din = '0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    idle_checks("postrst");
                    @(posedge clk); #1;
                end
                valid = 0;
                return;
            end
            valid = pick(mode, c);
        end
        if (!fin) chk("timeout", 0, 1);
        valid = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0; valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_checks("reset_idle");
        end
        @(posedge clk); #1 valid = 0;
        run_job(11'd16, 11'd4, 0, 0, 0);
        run_job(11'd16, 11'd4, 1, 0, 0);
        run_job(11'd2047, 11'd2, 2, 1, 0);
        run_job(11'd100, 11'd0, 0, 0, 0);
        run_job(11'd16, 11'd4, 0, 0, 1);
        run_job(11'd40, 11'd3, 0, 2, 0);
        run_job(11'd2045, 11'd5, 1, 2, 0);
        for (int j = 0; j < 8; j++)
            run_job(AW'($urandom), AW'($urandom_range(1, 12)), 2, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
